// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit byte stream between NREQ requesters, granting whole
// messages round-robin with a burst limit and an idle timeout per grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NREQ-1:0]                       req_valid_i,
  input  logic [NREQ-1:0][UART_BYTE_W-1:0]      req_data_i,
  input  logic [NREQ-1:0]                       req_last_i,
  output logic [NREQ-1:0]                       req_ready_o,
  output logic                                  tx_valid_o,
  output logic [UART_BYTE_W-1:0]                tx_data_o,
  input  logic                                  tx_ready_i,
  output logic [NREQ-1:0]                       gnt_o,
  output logic                                  busy_o,
  output logic                                  revoke_o
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t             state, state_nxt;
  logic [NREQ-1:0]        gnt, pick;
  logic                   any;
  logic [PW-1:0]          ptr, g_idx;
  logic [BW-1:0]          burst_cnt;
  logic [IW-1:0]          idle_cnt;
  logic                   revoke;
  logic                   valid_g, last_g;
  logic [UART_BYTE_W-1:0] data_g;
  logic                   beat, end_last, end_burst, end_idle, release_g;

  rr_pick #(.N(NREQ)) u_pick (
    .req  (req_valid_i),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  // gnt is all-zero outside GRANT, so the selected signals read as idle there.
  always_comb begin
    g_idx   = '0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    data_g  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        g_idx   = PW'(i);
        valid_g = req_valid_i[i];
        last_g  = req_last_i[i];
        data_g  = req_data_i[i];
      end
    end
  end

  assign beat      = (state == ARB_GRANT) && valid_g && tx_ready_i;
  assign end_last  = beat && last_g;
  assign end_burst = beat && ((burst_cnt + BW'(1)) == BW'(MAX_BURST));
  assign end_idle  = (state == ARB_GRANT) && !valid_g &&
                     ((idle_cnt + IW'(1)) == IW'(IDLE_TIMEOUT));
  assign release_g = end_last || end_burst || end_idle;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (any)       state_nxt = ARB_GRANT;
      ARB_GRANT: if (release_g) state_nxt = ARB_IDLE;
      default:                  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state == ARB_GRANT);
    gnt_o       = gnt;
    revoke_o    = revoke;
    tx_valid_o  = valid_g;
    tx_data_o   = valid_g ? data_g : '0;
    req_ready_o = (state == ARB_GRANT) ? (gnt & {NREQ{tx_ready_i}}) : '0;
  end

  // last wins over the burst limit: a message ending exactly at the limit is not a revoke.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr       <= '0;
      gnt       <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      revoke    <= 1'b0;
    end else begin
      revoke <= (end_burst && !end_last) || end_idle;
      case (state)
        ARB_IDLE: begin
          if (any) begin
            gnt       <= pick;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        ARB_GRANT: begin
          if (release_g) begin
            gnt <= '0;
            ptr <= (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);
          end else if (beat) begin
            burst_cnt <= burst_cnt + BW'(1);
            idle_cnt  <= '0;
          end else if (!valid_g) begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid, req_last, req_ready, gnt;
  logic [3:0][7:0]  req_data;
  logic             tx_valid, tx_ready, busy, revoke;
  logic [7:0]       tx_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .MAX_BURST(16), .IDLE_TIMEOUT(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .gnt_o       (gnt),
    .busy_o      (busy),
    .revoke_o    (revoke)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ready;
    logic [3:0]  e_gnt;
    logic        e_busy;
    logic        e_rev;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic [3:0]  e_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic [31:0] d, logic rd,
                              logic [3:0] eg, logic eb, logic er, logic ev, logic [7:0] ed,
                              logic [3:0] erd);
    vec_t t;
    t.rst = r; t.valid = v; t.last = l; t.data = d; t.ready = rd;
    t.e_gnt = eg; t.e_busy = eb; t.e_rev = er; t.e_txv = ev; t.e_txd = ed; t.e_rdy = erd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " gnt"},   32'(gnt), 0);
    chk({tag, " busy"},  32'(busy), 0);
    chk({tag, " rev"},   32'(revoke), 0);
    chk({tag, " txv"},   32'(tx_valid), 0);
    chk({tag, " txd"},   32'(tx_data), 0);
    chk({tag, " rdy"},   32'(req_ready), 0);
  endtask

  logic [3:0] bg[$];
  logic [7:0] bd[$];
  int         bc[$];
  int         rc[$];
  logic [7:0] ex_d[7]   = '{8'h00, 8'h51, 8'h52, 8'h52, 8'h52, 8'h53, 8'h00};
  logic [3:0] ex_rdy[7] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
  logic       ex_v[7]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       rdy_seq[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx1, idx3, sent0, sent2, sent1, nrev;
    logic [3:0]  eg[$];
    logic [7:0]  ed[$];
    int          ec[$];

    // Two 3-byte messages, then all four requesters with 1-byte messages.
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 32'h00C000A0, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 32'h00C000A0, 1, 4'b0001, 1, 0, 1, 8'hA0, 4'b0001));
    vecs.push_back(mk(0, 4'b0101, 4'b0000, 32'h00C000A1, 1, 4'b0001, 1, 0, 1, 8'hA1, 4'b0001));
    vecs.push_back(mk(0, 4'b0101, 4'b0001, 32'h00C000A2, 1, 4'b0001, 1, 0, 1, 8'hA2, 4'b0001));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'h00C00000, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'h00C00000, 1, 4'b0100, 1, 0, 1, 8'hC0, 4'b0100));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 32'h00C10000, 1, 4'b0100, 1, 0, 1, 8'hC1, 4'b0100));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 32'h00C20000, 1, 4'b0100, 1, 0, 1, 8'hC2, 4'b0100));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
    for (int k = 0; k < 5; k++) begin
      logic [3:0] g;
      logic [7:0] d;
      g = 4'b0001 << (k % 4);
      d = 8'h10 + 8'(k % 4);
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));
      vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'h13121110, 1, g, 1, 0, 1, d, g));
    end
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000));

    do_reset();
    chk_idle("reset");

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      req_data  = vecs[i].data;
      tx_ready  = vecs[i].ready;
      #3;
      chk($sformatf("v%0d gnt", i),  32'(gnt),       32'(vecs[i].e_gnt));
      chk($sformatf("v%0d busy", i), 32'(busy),      32'(vecs[i].e_busy));
      chk($sformatf("v%0d rev", i),  32'(revoke),    32'(vecs[i].e_rev));
      chk($sformatf("v%0d txv", i),  32'(tx_valid),  32'(vecs[i].e_txv));
      chk($sformatf("v%0d txd", i),  32'(tx_data),   32'(vecs[i].e_txd));
      chk($sformatf("v%0d rdy", i),  32'(req_ready), 32'(vecs[i].e_rdy));
      next_cycle();
    end
    rst = 1'b0;

    // Burst limit: 40-byte message on req 1 against a 2-byte message on req 3.
    do_reset();
    idx1 = 0;
    idx3 = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      quiet_inputs();
      req_valid[1] = (idx1 < 40);
      req_data[1]  = 8'(idx1);
      req_last[1]  = (idx1 == 39);
      req_valid[3] = (idx3 < 2);
      req_data[3]  = 8'hD0 + 8'(idx3);
      req_last[3]  = (idx3 == 1);
      #3;
      if (tx_valid && tx_ready) begin
        bg.push_back(gnt);
        bd.push_back(tx_data);
        bc.push_back(cyc);
      end
      if (revoke) rc.push_back(cyc);
      if (req_ready[1]) idx1++;
      if (req_ready[3]) idx3++;
      next_cycle();
    end
    for (int n = 0; n < 16; n++) begin eg.push_back(4'b0010); ed.push_back(8'(n)); ec.push_back(1 + n); end
    eg.push_back(4'b1000); ed.push_back(8'hD0); ec.push_back(18);
    eg.push_back(4'b1000); ed.push_back(8'hD1); ec.push_back(19);
    for (int n = 16; n < 32; n++) begin eg.push_back(4'b0010); ed.push_back(8'(n)); ec.push_back(n + 5); end
    for (int n = 32; n < 40; n++) begin eg.push_back(4'b0010); ed.push_back(8'(n)); ec.push_back(n + 6); end
    chk("burst beat count", 32'(bd.size()), 32'(ed.size()));
    for (int i = 0; i < ed.size() && i < bd.size(); i++) begin
      chk($sformatf("burst b%0d gnt", i),  32'(bg[i]), 32'(eg[i]));
      chk($sformatf("burst b%0d data", i), 32'(bd[i]), 32'(ed[i]));
      chk($sformatf("burst b%0d cyc", i),  32'(bc[i]), 32'(ec[i]));
    end
    chk("burst revoke count", 32'(rc.size()), 2);
    if (rc.size() >= 1) chk("burst revoke0 cyc", 32'(rc[0]), 17);
    if (rc.size() >= 2) chk("burst revoke1 cyc", 32'(rc[1]), 37);

    // Idle timeout: req 0 stalls after two bytes while req 2 waits.
    do_reset();
    sent0 = 0;
    sent2 = 0;
    nrev  = 0;
    for (int cyc = 0; cyc < 71; cyc++) begin
      quiet_inputs();
      req_valid[0] = (sent0 < 2);
      req_data[0]  = 8'h30 + 8'(sent0);
      req_valid[2] = (sent2 < 1);
      req_data[2]  = 8'hEE;
      req_last[2]  = 1'b1;
      #3;
      if (revoke) nrev++;
      if (cyc == 2) begin
        chk("tmo last beat data", 32'(tx_data), 8'h31);
        chk("tmo last beat gnt", 32'(gnt), 4'b0001);
      end
      if (cyc == 66) begin
        chk("tmo c66 busy", 32'(busy), 1);
        chk("tmo c66 gnt", 32'(gnt), 4'b0001);
        chk("tmo c66 rev", 32'(revoke), 0);
      end
      if (cyc == 67) begin
        chk("tmo c67 busy", 32'(busy), 0);
        chk("tmo c67 rev", 32'(revoke), 1);
      end
      if (cyc == 68) begin
        chk("tmo c68 gnt", 32'(gnt), 4'b0100);
        chk("tmo c68 txd", 32'(tx_data), 8'hEE);
        chk("tmo c68 rev", 32'(revoke), 0);
      end
      if (req_ready[0]) sent0++;
      if (req_ready[2]) sent2++;
      next_cycle();
    end
    chk("tmo revoke count", 32'(nrev), 1);

    // Back-pressure: tx_ready toggles during a 3-byte message from req 1.
    do_reset();
    sent1 = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      quiet_inputs();
      req_valid[1] = (sent1 < 3);
      req_data[1]  = 8'h51 + 8'(sent1);
      req_last[1]  = (sent1 == 2);
      tx_ready     = rdy_seq[cyc];
      #3;
      chk($sformatf("bp c%0d txv", cyc), 32'(tx_valid),  32'(ex_v[cyc]));
      chk($sformatf("bp c%0d txd", cyc), 32'(tx_data),   32'(ex_d[cyc]));
      chk($sformatf("bp c%0d rdy", cyc), 32'(req_ready), 32'(ex_rdy[cyc]));
      if (req_ready[1]) sent1++;
      next_cycle();
    end
    chk("bp bytes sent", 32'(sent1), 3);

    // Reset mid-message: ptr was 3, after reset the lowest valid index wins.
    do_reset();
    quiet_inputs();
    req_valid = 4'b0100; req_last = 4'b0100; req_data = 32'h00770000;
    #3; chk("rst c0 gnt", 32'(gnt), 0);
    next_cycle();
    #3; chk("rst c1 gnt", 32'(gnt), 4'b0100); chk("rst c1 txd", 32'(tx_data), 8'h77);
    next_cycle();
    req_valid = 4'b1010; req_last = 4'b0000; req_data = 32'h33001100;
    #3; chk("rst c2 gnt", 32'(gnt), 0);
    next_cycle();
    #3; chk("rst c3 gnt", 32'(gnt), 4'b1000); chk("rst c3 txd", 32'(tx_data), 8'h33);
    next_cycle();
    rst = 1'b1;
    #3; chk("rst c4 gnt", 32'(gnt), 4'b1000);
    next_cycle();
    rst = 1'b0;
    #3; chk_idle("rst c5");
    next_cycle();
    #3; chk("rst c6 gnt", 32'(gnt), 4'b0010); chk("rst c6 txd", 32'(tx_data), 8'h11);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
